// File: rtl/pixel_stream_lcd_encoder_if.sv
// Pixel write stream in, ST7789 command/data byte stream out.
// The master modport is the pixel source / SPI shifter side. The slave modport is the encoder.
interface pixel_stream_lcd_encoder_if;
  logic        req_pixel;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [15:0] pixel_color;
  logic        stream_break;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic        byte_dc;

  modport master (
    output req_pixel, pixel_x, pixel_y, pixel_color, stream_break, byte_ready,
    input  byte_valid, byte_data, byte_dc
  );

  modport slave (
    input  req_pixel, pixel_x, pixel_y, pixel_color, stream_break, byte_ready,
    output byte_valid, byte_data, byte_dc
  );
endinterface

// File: rtl/pixel_stream_lcd_encoder.sv
// Buffers per-pixel writes in a small FIFO and encodes each one as ST7789 CASET/RASET/RAMWR bytes.
// Raster-contiguous pixels are appended to an already open RAMWR stream.
module pixel_stream_lcd_encoder #(
  parameter int SCREEN_W = 240,
  parameter int SCREEN_H = 320,
  parameter int FIFO_AW  = 4
) (
  input  logic clk,
  input  logic rst_n,
  pixel_stream_lcd_encoder_if.slave bus,
  output logic fifo_full,
  output logic busy,
  output logic err_overflow,
  output logic err_range
);

  typedef struct packed {
    logic [9:0]  y;
    logic [9:0]  x;
    logic [15:0] color;
  } pixel_t;

  typedef enum logic [2:0] {
    S_IDLE, S_CASET, S_XDATA, S_RASET, S_YDATA, S_RAMWR, S_CHI, S_CLO
  } state_t;

  localparam int               DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [9:0]       X_END = 10'(SCREEN_W - 1);
  localparam logic [9:0]       Y_END = 10'(SCREEN_H - 1);

  pixel_t               mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]     count;
  logic                 fifo_empty, in_range, push, pop, cont;
  pixel_t               head, cur;

  state_t     state;
  logic [1:0] idx;
  logic [9:0] last_x, last_y;
  logic       stream_open, break_seen;
  logic       out_valid, out_dc;
  logic [7:0] out_data;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_COUNT);
  assign in_range   = (bus.pixel_x <= X_END) && (bus.pixel_y <= Y_END);
  assign push       = bus.req_pixel && in_range && !fifo_full;
  assign pop        = (state == S_IDLE) && !fifo_empty;
  assign head       = mem[rd_ptr];
  assign busy       = !fifo_empty || (state != S_IDLE);

  assign bus.byte_valid = out_valid;
  assign bus.byte_data  = out_data;
  assign bus.byte_dc    = out_dc;

  // Next pixel on the same row, or first pixel of the next row after the last column.
  assign cont = stream_open &&
                ((head.y == last_y && head.x == last_x + 10'd1) ||
                 (last_x == X_END && head.x == 10'd0 &&
                  last_y < Y_END && head.y == last_y + 10'd1));

  // {dc, data} for a given state and data-phase index.
  function automatic logic [8:0] byte_for(state_t st, logic [1:0] i, pixel_t px);
    logic [9:0] coord;
    logic [9:0] lim;
    logic [8:0] b;
    b     = '0;
    coord = (st == S_XDATA) ? px.x : px.y;
    lim   = (st == S_XDATA) ? X_END : Y_END;
    case (st)
      S_CASET: b = {1'b0, 8'h2A};
      S_RASET: b = {1'b0, 8'h2B};
      S_RAMWR: b = {1'b0, 8'h2C};
      S_XDATA, S_YDATA: begin
        case (i)
          2'd0:    b = {1'b1, 6'b0, coord[9:8]};
          2'd1:    b = {1'b1, coord[7:0]};
          2'd2:    b = {1'b1, 6'b0, lim[9:8]};
          default: b = {1'b1, lim[7:0]};
        endcase
      end
      S_CHI:   b = {1'b1, px.color[15:8]};
      S_CLO:   b = {1'b1, px.color[7:0]};
      default: b = '0;
    endcase
    return b;
  endfunction

  // NOTE: storage array has no reset; only pointers and count need one, which keeps it RAM-inferable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pixel_t'{y: bus.pixel_y, x: bus.pixel_x, color: bus.pixel_color};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Overflow uses fullness at the edge, so a pop in the same cycle does not rescue the pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_range    <= 1'b0;
      err_overflow <= 1'b0;
    end else if (bus.req_pixel) begin
      if (!in_range)      err_range    <= 1'b1;
      else if (fifo_full) err_overflow <= 1'b1;
    end
  end

  // NOTE: nonblocking throughout; later assignments in this block deliberately override earlier ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      cur         <= '0;
      last_x      <= '0;
      last_y      <= '0;
      stream_open <= 1'b0;
      break_seen  <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_dc      <= 1'b0;
    end else begin
      // A break during a sequence must also stop the coming RAMWR from reopening the stream.
      if (bus.stream_break) begin
        stream_open <= 1'b0;
        break_seen  <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (pop) begin
            cur        <= head;
            last_x     <= head.x;
            last_y     <= head.y;
            break_seen <= bus.stream_break;
            idx        <= '0;
            out_valid  <= 1'b1;
            if (cont) begin
              state              <= S_CHI;
              {out_dc, out_data} <= byte_for(S_CHI, 2'd0, head);
            end else begin
              state              <= S_CASET;
              {out_dc, out_data} <= byte_for(S_CASET, 2'd0, head);
            end
          end
        end
        default: begin
          if (out_valid && bus.byte_ready) begin
            case (state)
              S_CASET: begin
                state              <= S_XDATA;
                {out_dc, out_data} <= byte_for(S_XDATA, 2'd0, cur);
              end
              S_XDATA: begin
                if (idx == 2'd3) begin
                  state              <= S_RASET;
                  idx                <= '0;
                  {out_dc, out_data} <= byte_for(S_RASET, 2'd0, cur);
                end else begin
                  idx                <= idx + 2'd1;
                  {out_dc, out_data} <= byte_for(S_XDATA, idx + 2'd1, cur);
                end
              end
              S_RASET: begin
                state              <= S_YDATA;
                {out_dc, out_data} <= byte_for(S_YDATA, 2'd0, cur);
              end
              S_YDATA: begin
                if (idx == 2'd3) begin
                  state              <= S_RAMWR;
                  idx                <= '0;
                  {out_dc, out_data} <= byte_for(S_RAMWR, 2'd0, cur);
                end else begin
                  idx                <= idx + 2'd1;
                  {out_dc, out_data} <= byte_for(S_YDATA, idx + 2'd1, cur);
                end
              end
              S_RAMWR: begin
                state              <= S_CHI;
                stream_open        <= !(break_seen || bus.stream_break);
                {out_dc, out_data} <= byte_for(S_CHI, 2'd0, cur);
              end
              S_CHI: begin
                state              <= S_CLO;
                {out_dc, out_data} <= byte_for(S_CLO, 2'd0, cur);
              end
              S_CLO: begin
                state     <= S_IDLE;
                out_valid <= 1'b0;
              end
              default: begin
                state     <= S_IDLE;
                out_valid <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_stream_lcd_encoder.sv
// Randomised and directed bench for pixel_stream_lcd_encoder against a pixel-level byte-sequence model.
module tb_pixel_stream_lcd_encoder;

  localparam int W = 240;
  localparam int H = 320;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fifo_full, busy, err_overflow, err_range;

  pixel_stream_lcd_encoder_if bus();

  pixel_stream_lcd_encoder #(.SCREEN_W(W), .SCREEN_H(H), .FIFO_AW(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .fifo_full(fifo_full),
    .busy(busy),
    .err_overflow(err_overflow),
    .err_range(err_range)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];

  bit m_open;
  int m_lx, m_ly;

  bit   rand_ready = 1'b0;
  logic ready_set = 1'b0;
  logic rnd_ready = 1'b0;
  assign bus.byte_ready = rand_ready ? rnd_ready : ready_set;

  always @(negedge clk) rnd_ready = ($urandom_range(0, 3) != 0);

  // Capture accepted bytes and check that an offered byte is held until taken.
  logic [8:0] held;
  bit         pending = 1'b0;
  always @(posedge clk) begin
    if (!rst_n) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        vectors++;
        if (bus.byte_valid !== 1'b1 || {bus.byte_dc, bus.byte_data} !== held) begin
          miscompares++;
          $display("FAIL hold_stable: got valid=%b dc/data=%h, want valid=1 dc/data=%h",
                   bus.byte_valid, {bus.byte_dc, bus.byte_data}, held);
        end
      end
      if (bus.byte_valid && bus.byte_ready) obs_q.push_back({bus.byte_dc, bus.byte_data});
      pending = bus.byte_valid && !bus.byte_ready;
      held    = {bus.byte_dc, bus.byte_data};
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_open = 1'b0;
    m_lx = 0;
    m_ly = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic model_pixel(input int x, input int y, input int c);
    bit cont;
    if (x >= W || y >= H) return;
    cont = m_open && ((y == m_ly && x == m_lx + 1) ||
                      (m_lx == W - 1 && x == 0 && y == m_ly + 1 && m_ly < H - 1));
    m_lx = x;
    m_ly = y;
    if (!cont) begin
      exp_q.push_back(9'h02A);
      exp_q.push_back(9'(256 + x / 256));
      exp_q.push_back(9'(256 + x % 256));
      exp_q.push_back(9'(256 + (W - 1) / 256));
      exp_q.push_back(9'(256 + (W - 1) % 256));
      exp_q.push_back(9'h02B);
      exp_q.push_back(9'(256 + y / 256));
      exp_q.push_back(9'(256 + y % 256));
      exp_q.push_back(9'(256 + (H - 1) / 256));
      exp_q.push_back(9'(256 + (H - 1) % 256));
      exp_q.push_back(9'h02C);
    end
    exp_q.push_back(9'(256 + c / 256));
    exp_q.push_back(9'(256 + c % 256));
    m_open = 1'b1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic push_px(input int x, input int y, input int c, input bit accepted);
    @(negedge clk);
    bus.req_pixel   = 1'b1;
    bus.pixel_x     = 10'(x);
    bus.pixel_y     = 10'(y);
    bus.pixel_color = 16'(c);
    if (accepted) model_pixel(x, y, c);
  endtask

  task automatic req_off();
    @(negedge clk);
    bus.req_pixel = 1'b0;
  endtask

  task automatic pulse_break();
    @(negedge clk);
    bus.stream_break = 1'b1;
    @(negedge clk);
    bus.stream_break = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!busy && !bus.byte_valid) break;
    end
    vectors++;
    if (n >= 3000) begin
      miscompares++;
      $display("FAIL %s_drain: got busy=%b after 3000 cycles, want busy=0", name, busy);
    end
  endtask

  task automatic compare_stream(input string name, input int want_len);
    int n;
    vectors++;
    if (obs_q.size() != want_len || exp_q.size() != want_len) begin
      miscompares++;
      $display("FAIL %s_len: got %0d bytes, want %0d (model %0d)",
               name, obs_q.size(), want_len, exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL %s_byte%0d: got dc/data=%h, want %h", name, i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.req_pixel    = 1'b0;
    bus.pixel_x      = '0;
    bus.pixel_y      = '0;
    bus.pixel_color  = '0;
    bus.stream_break = 1'b0;
    ready_set        = 1'b1;
    rst_n            = 1'b0;
    model_reset();
    #12;
    vectors++;
    if ({bus.byte_valid, bus.byte_dc, bus.byte_data, fifo_full, busy, err_overflow, err_range} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b dc=%b d=%h full=%b busy=%b ovf=%b rng=%b, want all 0",
               bus.byte_valid, bus.byte_dc, bus.byte_data, fifo_full, busy, err_overflow, err_range);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_latency();
    push_px(5, 7, 16'hF800, 1'b1);   // req high in cycle 0
    req_off();                       // cycle 1
    vectors++;
    if (bus.byte_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL latency_c1: got valid=%b busy=%b, want valid=0 busy=1", bus.byte_valid, busy);
    end
    @(negedge clk);                  // cycle 2
    vectors++;
    if (bus.byte_valid !== 1'b1 || {bus.byte_dc, bus.byte_data} !== 9'h02A) begin
      miscompares++;
      $display("FAIL latency_c2: got valid=%b dc/data=%h, want valid=1 02a",
               bus.byte_valid, {bus.byte_dc, bus.byte_data});
    end
    repeat (12) @(negedge clk);      // cycle 14
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_c14: got %b, want 1", busy);
    end
    @(negedge clk);                  // cycle 15
    vectors++;
    if (busy !== 1'b0 || obs_q.size() != 13) begin
      miscompares++;
      $display("FAIL busy_c15: got busy=%b bytes=%0d, want busy=0 bytes=13", busy, obs_q.size());
    end
    compare_stream("single", 13);
  endtask

  task automatic test_continuation();
    push_px(10, 3, 16'h1234, 1'b1);
    push_px(11, 3, 16'h5678, 1'b1);
    push_px(13, 3, 16'h9ABC, 1'b1);
    req_off();
    wait_drain("cont");
    compare_stream("cont", 28);
  endtask

  task automatic test_row_wrap();
    push_px(239, 4, 16'h0F0F, 1'b1);
    push_px(0, 5, 16'hF0F0, 1'b1);
    req_off();
    wait_drain("wrap");
    compare_stream("wrap", 15);
    push_px(239, 319, 16'hAAAA, 1'b1);
    push_px(0, 0, 16'h5555, 1'b1);
    req_off();
    wait_drain("corner");
    compare_stream("corner", 26);
  endtask

  task automatic test_range();
    vectors++;
    if (err_range !== 1'b0) begin
      miscompares++;
      $display("FAIL range_pre: got err_range=%b, want 0", err_range);
    end
    push_px(240, 0, 16'h1111, 1'b0);
    push_px(0, 320, 16'h2222, 1'b0);
    req_off();
    repeat (5) @(negedge clk);
    vectors++;
    if (err_range !== 1'b1 || err_overflow !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL range_flags: got rng=%b ovf=%b busy=%b, want rng=1 ovf=0 busy=0",
               err_range, err_overflow, busy);
    end
    compare_stream("range", 0);
  endtask

  task automatic test_break();
    int n;
    push_px(20, 9, 16'hC0DE, 1'b1);
    req_off();
    wait_drain("brk_a");
    compare_stream("brk_a", 13);
    pulse_break();
    m_open = 1'b0;
    push_px(21, 9, 16'hBEEF, 1'b1);
    req_off();
    wait_drain("brk_idle");
    compare_stream("brk_idle", 13);
    // Break while a fresh pixel is stalled before its RAMWR.
    ready_set = 1'b0;
    push_px(30, 9, 16'h0101, 1'b1);
    req_off();
    for (n = 0; n < 10 && !bus.byte_valid; n++) @(negedge clk);
    pulse_break();
    m_open = 1'b0;
    push_px(31, 9, 16'h0202, 1'b1);
    req_off();
    ready_set = 1'b1;
    wait_drain("brk_mid");
    compare_stream("brk_mid", 26);
  endtask

  task automatic test_random();
    int px, py, x, y, c, n, mode;
    px = m_lx;
    py = m_ly;
    rand_ready = 1'b1;
    for (int b = 0; b < 30; b++) begin
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++) begin
        mode = $urandom_range(0, 9);
        if (mode < 5) begin
          x = px + 1;
          y = py;
          if (x == W) begin
            x = 0;
            y = (py == H - 1) ? 0 : py + 1;
          end
        end else if (mode < 7) begin
          x = $urandom_range(0, W - 1);
          y = $urandom_range(0, H - 1);
        end else if (mode == 7) begin
          x = ($urandom_range(0, 1) != 0) ? W - 1 : 0;
          y = ($urandom_range(0, 1) != 0) ? H - 1 : py;
        end else if (mode == 8) begin
          x = $urandom_range(0, 1023);
          y = $urandom_range(0, 1023);
        end else begin
          x = px + 2;
          y = py;
        end
        if (x >= 1024) x = 0;
        c = $urandom_range(0, 16'hFFFF);
        push_px(x, y, c, 1'b1);
        if (x < W && y < H) begin
          px = x;
          py = y;
        end
        if ($urandom_range(0, 3) == 0) req_off();
      end
      req_off();
      wait_drain("rand");
      compare_stream("rand", exp_q.size());
      if ($urandom_range(0, 3) == 0) begin
        pulse_break();
        m_open = 1'b0;
      end
    end
    rand_ready = 1'b0;
    ready_set  = 1'b1;
    vectors++;
    if (err_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL rand_no_ovf: got err_overflow=%b, want 0", err_overflow);
    end
  endtask

  task automatic test_overflow();
    int n, bad;
    ready_set = 1'b0;
    push_px(100, 60, 16'h7E7E, 1'b1);
    req_off();
    for (n = 0; n < 10 && !bus.byte_valid; n++) @(negedge clk);
    vectors++;
    if (bus.byte_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_first_byte: got valid=%b, want 1", bus.byte_valid);
    end
    for (int i = 0; i < 20; i++) push_px(i, 50, 16'h0100 + i, i < 16);
    req_off();
    vectors++;
    if (fifo_full !== 1'b1 || err_overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_flags: got full=%b ovf=%b, want full=1 ovf=1", fifo_full, err_overflow);
    end
    bad = 0;
    repeat (26) begin
      @(negedge clk);
      if (bus.byte_valid !== 1'b1 || {bus.byte_dc, bus.byte_data} !== 9'h02A) bad++;
    end
    vectors++;
    if (bad != 0 || obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL ovf_stall: got %0d unstable cycles, %0d bytes taken, want 0 and 0", bad, obs_q.size());
    end
    ready_set = 1'b1;
    wait_drain("ovf");
    compare_stream("ovf", 56);
  endtask

  task automatic test_reset_mid();
    int n;
    push_px(50, 60, 16'h3C3C, 1'b1);
    req_off();
    for (n = 0; n < 40 && obs_q.size() < 6; n++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.byte_valid !== 1'b0 || busy !== 1'b0 || err_range !== 1'b0 || err_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got valid=%b busy=%b rng=%b ovf=%b, want all 0",
               bus.byte_valid, busy, err_range, err_overflow);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    compare_stream("post_reset_quiet", 0);
    push_px(51, 60, 16'h4D4D, 1'b1);
    req_off();
    wait_drain("post_reset");
    compare_stream("post_reset", 13);
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_continuation();
    test_row_wrap();
    test_range();
    test_break();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
